// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI3 slave in front of a 32-bit wide
// synchronous SRAM (read data valid the cycle after ram_en).
// Optional feature macro: AXI_SRAM_SLAVE_DECERR_EN -- start addresses beyond
// the SRAM window answer DECERR and never touch the SRAM; without it the upper
// address bits are dropped and accesses alias into the SRAM.
module axi_sram_slave #(
  parameter int MEM_AW = 16
) (
  input  logic              aclk,
  input  logic              areset,
  // AR channel
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  // R channel
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // AW channel
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  // W channel
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // B channel
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_e            state_q, state_d;
  logic              wr_last_q, wr_last_d;   // 1: write channel was granted last
  logic [3:0]        id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;           // wlast disagreed with the beat count
  logic              dec_q, dec_d;           // transaction decodes outside the SRAM
  logic              rd_first_q, rd_first_d; // first cycle of RD_DATA: SRAM output is live
  logic [31:0]       rdata_q, rdata_d;

  logic              ar_dec, aw_dec, last_beat;
  logic [31:0]       rd_word;
  logic [MEM_AW-1:0] addr_next;

`ifdef AXI_SRAM_SLAVE_DECERR_EN
  assign ar_dec = (araddr[31:MEM_AW+2] != '0);
  assign aw_dec = (awaddr[31:MEM_AW+2] != '0);
`else
  assign ar_dec = 1'b0;
  assign aw_dec = 1'b0;
`endif

  // Size, write id and the unused address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{arsize, awsize, wid, araddr, awaddr};

  assign last_beat = (beat_q == len_q);
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q
                                              : addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
  assign rd_word   = dec_q ? 32'd0 : ram_rdata;

  // While the beat is first presented the SRAM output is shown directly; the
  // hold register keeps it stable for any following stall cycles.
  assign rdata = rd_first_q ? rd_word : rdata_q;
  assign rid   = id_q;
  assign bid   = id_q;
  assign rlast = (state_q == RD_DATA) && last_beat;
  assign rresp = (state_q == RD_DATA && dec_q) ? RESP_DECERR : RESP_OKAY;
  assign bresp = (state_q != WR_RESP) ? RESP_OKAY   :
                 dec_q                ? RESP_DECERR :
                 err_q                ? RESP_SLVERR : RESP_OKAY;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata;

  // Next-state, handshake and SRAM strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    wr_last_d  = wr_last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    dec_d      = dec_q;
    rdata_d    = rdata_q;
    rd_first_d = (state_q == RD_ADDR);
    arready    = 1'b0;
    awready    = 1'b0;
    rvalid     = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    ram_en     = 1'b0;
    ram_wen    = 4'b0000;

    case (state_q)
      IDLE: begin
        arready = arvalid && (!awvalid || wr_last_q);
        awready = awvalid && (!arvalid || !wr_last_q);
        if (arready) begin
          id_d      = arid;
          addr_d    = araddr[MEM_AW+1:2];
          len_d     = arlen;
          burst_d   = arburst;
          beat_d    = 8'd0;
          dec_d     = ar_dec;
          wr_last_d = 1'b0;
          state_d   = RD_ADDR;
        end else if (awready) begin
          id_d      = awid;
          addr_d    = awaddr[MEM_AW+1:2];
          len_d     = awlen;
          burst_d   = awburst;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          dec_d     = aw_dec;
          wr_last_d = 1'b1;
          state_d   = WR_DATA;
        end
      end
      RD_ADDR: begin
        ram_en  = !dec_q;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (rd_first_q) rdata_d = rd_word;
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = RD_ADDR;
          end
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en  = !dec_q;
          ram_wen = dec_q ? 4'b0000 : wstrb;
          if (wlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Nothing is accepted and the SRAM is left alone while reset is applied.
    if (areset) begin
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      ram_en  = 1'b0;
      ram_wen = 4'b0000;
    end
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (areset) begin
      state_q    <= IDLE;
      wr_last_q  <= 1'b1;
      id_q       <= 4'd0;
      addr_q     <= '0;
      len_q      <= 8'd0;
      burst_q    <= 2'b00;
      beat_q     <= 8'd0;
      err_q      <= 1'b0;
      dec_q      <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wr_last_q  <= wr_last_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      dec_q      <= dec_d;
      rd_first_q <= rd_first_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: SRAM model, table of single-beat transactions
// and hand-written sequences for bursts, stalls, arbitration and reset.
module tb_axi_sram_slave;
  localparam int MEM_AW = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata, ram_wdata, ram_rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb, ram_wen;
  logic        ram_en;
  logic [MEM_AW-1:0] ram_addr;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // SRAM model: byte-enabled writes, registered read data.
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  int en_cnt = 0;
  int wr_cnt = 0;
  always @(posedge aclk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_wen != 4'b0000) begin
        wr_cnt <= wr_cnt + 1;
        for (int i = 0; i < 4; i++)
          if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [3:0]  ridb [16];
  logic [1:0]  rrespb [16];
  logic        rlastb [16];

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int early_last,
                          output logic [3:0] got_bid, output logic [1:0] got_bresp, output bit ok);
    int n;
    ok = 1'b0;
    got_bid = 4'h0;
    got_bresp = 2'b00;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); #1; n++; end
    if (!awready) begin awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wid = 4'hF;
      wlast = (b == int'(len)) || (b == early_last);
      #1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); #1; n++; end
      if (!wready) begin wvalid = 1'b0; return; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); #1; n++; end
    if (!bvalid) begin bready = 1'b0; return; end
    got_bid = bid;
    got_bresp = bresp;
    ok = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // With stall set, every beat is held off for one cycle and must not change.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall,
                         output int nbeats, output bit ok);
    int n;
    bit held, done;
    logic [31:0] hold_data;
    logic hold_last;
    ok = 1'b0;
    nbeats = 0;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
    if (!arready) begin arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    held = 1'b0; done = 1'b0; n = 0;
    hold_data = 32'd0; hold_last = 1'b0;
    while (!done && n < 200) begin
      #1;
      if (rvalid) begin
        if (stall && !held) begin
          held = 1'b1; hold_data = rdata; hold_last = rlast;
        end else begin
          if (held) begin
            check($sformatf("rd_stable_data_b%0d", nbeats), rdata, hold_data);
            check($sformatf("rd_stable_last_b%0d", nbeats), 32'(rlast), 32'(hold_last));
          end
          held = 1'b0;
          rready = 1'b1;
          rbuf[nbeats] = rdata; ridb[nbeats] = rid; rrespb[nbeats] = rresp; rlastb[nbeats] = rlast;
          nbeats++;
          if (rlast || nbeats >= 16) done = 1'b1;
        end
      end
      @(negedge aclk);
      rready = 1'b0;
      n++;
    end
    ok = done;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_en;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gb;
    logic [1:0] gr;
    bit ok;
    int nb, en0, wr0, n, ng, both_cnt;
    logic [1:0] g [3];

    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    // Reset held 3 cycles with both address channels requesting.
    areset = 1'b1; arvalid = 1'b1; awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); #1;
      check($sformatf("rst_ctrl_c%0d", i), 32'({arready, awready, rvalid, bvalid, ram_en}), 32'd0);
    end
    check("rst_rdata", rdata, 32'd0);
    check("rst_ids_resp", 32'({rid, bid, rresp, bresp, wready, ram_wen}), 32'd0);
    @(negedge aclk);
    areset = 1'b0; arvalid = 1'b0; awvalid = 1'b0;

    vecs[0] = '{1'b1, 4'h1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, 1};
    vecs[1] = '{1'b1, 4'h2, 32'h0000_0028, 32'hA5A5A5A5, 4'hF, 32'h0,        2'b00, 1};
    vecs[2] = '{1'b1, 4'h3, 32'h0000_0100, 32'h11223344, 4'hF, 32'h0,        2'b00, 1};
    vecs[3] = '{1'b1, 4'h4, 32'h0000_0100, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00, 1};
    vecs[4] = '{1'b0, 4'h5, 32'h0000_0100, 32'h0,        4'h0, 32'h11BB33DD, 2'b00, 1};
    vecs[5] = '{1'b1, 4'hF, 32'h0003_FFFC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00, 1};
    vecs[6] = '{1'b0, 4'h0, 32'h0003_FFFC, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 1};
`ifdef AXI_SRAM_SLAVE_DECERR_EN
    vecs[7] = '{1'b0, 4'h6, 32'h4003_FFFC, 32'h0,        4'h0, 32'h0,        2'b11, 0};
`else
    vecs[7] = '{1'b0, 4'h6, 32'h4003_FFFC, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 1};
`endif

    for (int i = 0; i < 8; i++) begin
      en0 = en_cnt;
      if (vecs[i].wr) begin
        wbuf[0] = vecs[i].data; sbuf[0] = vecs[i].strb;
        do_write(vecs[i].id, vecs[i].addr, 8'd0, 2'b01, -1, gb, gr, ok);
        check($sformatf("v%0d_wr_done", i), 32'(ok), 32'd1);
        check($sformatf("v%0d_bid", i), 32'(gb), 32'(vecs[i].id));
        check($sformatf("v%0d_bresp", i), 32'(gr), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].id, vecs[i].addr, 8'd0, 2'b01, 1'b0, nb, ok);
        check($sformatf("v%0d_rd_done", i), 32'(ok), 32'd1);
        check($sformatf("v%0d_beats", i), 32'(nb), 32'd1);
        check($sformatf("v%0d_rdata", i), rbuf[0], vecs[i].exp_data);
        check($sformatf("v%0d_rid", i), 32'(ridb[0]), 32'(vecs[i].id));
        check($sformatf("v%0d_rresp", i), 32'(rrespb[0]), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rlast", i), 32'(rlastb[0]), 32'd1);
      end
      check($sformatf("v%0d_ram_en_cycles", i), 32'(en_cnt - en0), 32'(vecs[i].exp_en));
    end

    // Single read, cycle by cycle: SRAM strobe one cycle after the
    // handshake, data valid the cycle after that.
    @(negedge aclk);
    arid = 4'h5; araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    #1;
    check("sr_arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    #1;
    check("sr_c1_en_valid", 32'({ram_en, ram_wen, rvalid}), 32'b1_0000_0);
    check("sr_c1_addr", 32'(ram_addr), 32'd4);
    @(negedge aclk); #1;
    check("sr_c2_valid_en", 32'({rvalid, ram_en}), 32'b10);
    check("sr_c2_rdata", rdata, 32'hDEADBEEF);
    check("sr_c2_id_last_resp", 32'({rid, rlast, rresp}), 32'({4'h5, 1'b1, 2'b00}));
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    #1;
    check("sr_c3_done", 32'(rvalid), 32'd0);

    // 4-beat INCR write with a partial strobe on beat 2.
    wbuf[0] = 32'h0101_0101; sbuf[0] = 4'hF;
    wbuf[1] = 32'h0202_0202; sbuf[1] = 4'hF;
    wbuf[2] = 32'h1234_5678; sbuf[2] = 4'b0011;
    wbuf[3] = 32'h0404_0404; sbuf[3] = 4'hF;
    en0 = en_cnt;
    do_write(4'h9, 32'h20, 8'd3, 2'b01, -1, gb, gr, ok);
    check("wb_done", 32'(ok), 32'd1);
    check("wb_bid_bresp", 32'({gb, gr}), 32'({4'h9, 2'b00}));
    check("wb_en_cycles", 32'(en_cnt - en0), 32'd4);
    check("wb_word8", mem[8], 32'h0101_0101);
    check("wb_word9", mem[9], 32'h0202_0202);
    check("wb_word10", mem[10], 32'hA5A5_5678);
    check("wb_word11", mem[11], 32'h0404_0404);

    // Both address channels held high: the last grant was a write, so the
    // order must be read, write, read.
    @(negedge aclk);
    arid = 4'h2; araddr = 32'h0; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'h3; awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    wvalid = 1'b1; wdata = 32'h0000_0077; wstrb = 4'hF; wlast = 1'b1;
    rready = 1'b1; bready = 1'b1;
    ng = 0; n = 0; both_cnt = 0;
    while (ng < 3 && n < 60) begin
      #1;
      if (arready && awready) both_cnt++;
      else if (arready) begin g[ng] = 2'd1; ng++; end
      else if (awready) begin g[ng] = 2'd2; ng++; end
      @(negedge aclk);
      n++;
    end
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (4) @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;
    check("arb_grants", 32'(ng), 32'd3);
    check("arb_order", 32'({g[0], g[1], g[2]}), 32'({2'd1, 2'd2, 2'd1}));
    check("arb_both_ready", 32'(both_cnt), 32'd0);
    check("arb_write_data", mem[16], 32'h0000_0077);

    // 4-beat read back of the burst with every beat stalled one cycle.
    en0 = en_cnt;
    do_read(4'h7, 32'h20, 8'd3, 2'b01, 1'b1, nb, ok);
    check("bp_done", 32'(ok), 32'd1);
    check("bp_beats", 32'(nb), 32'd4);
    check("bp_d0", rbuf[0], 32'h0101_0101);
    check("bp_d1", rbuf[1], 32'h0202_0202);
    check("bp_d2", rbuf[2], 32'hA5A5_5678);
    check("bp_d3", rbuf[3], 32'h0404_0404);
    check("bp_rlast", 32'({rlastb[0], rlastb[1], rlastb[2], rlastb[3]}), 32'b0001);
    check("bp_rid", 32'(ridb[3]), 32'h7);
    check("bp_en_cycles", 32'(en_cnt - en0), 32'd4);

    // FIXED burst keeps re-reading the same word.
    do_read(4'h1, 32'h10, 8'd1, 2'b00, 1'b0, nb, ok);
    check("fx_beats", 32'(nb), 32'd2);
    check("fx_d0", rbuf[0], 32'hDEADBEEF);
    check("fx_d1", rbuf[1], 32'hDEADBEEF);

    // 2-beat write with wlast early on beat 0: counter still ends the burst,
    // response is SLVERR.
    wbuf[0] = 32'h0000_0055; sbuf[0] = 4'hF;
    wbuf[1] = 32'h0000_0066; sbuf[1] = 4'hF;
    do_write(4'hA, 32'h300, 8'd1, 2'b01, 0, gb, gr, ok);
    check("ew_done", 32'(ok), 32'd1);
    check("ew_bid_bresp", 32'({gb, gr}), 32'({4'hA, 2'b10}));
    check("ew_word0", mem[16'hC0], 32'h0000_0055);
    check("ew_word1", mem[16'hC1], 32'h0000_0066);

    // Reset in the middle of a 4-beat write: two beats land, no more.
    wr0 = wr_cnt;
    @(negedge aclk);
    awid = 4'hB; awaddr = 32'h400; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    #1;
    check("mr_awready", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h0000_0099; wstrb = 4'hF; wlast = 1'b0;
    #1;
    check("mr_wready", 32'(wready), 32'd1);
    @(negedge aclk);
    wdata = 32'h0000_0098;
    @(negedge aclk);
    areset = 1'b1; wdata = 32'h0000_0097;
    #1;
    check("mr_in_reset", 32'({wready, ram_en, awready, arready}), 32'd0);
    @(negedge aclk);
    areset = 1'b0; wvalid = 1'b0;
    #1;
    check("mr_after_reset", 32'({wready, bvalid, ram_en}), 32'd0);
    repeat (3) @(negedge aclk);
    check("mr_write_count", 32'(wr_cnt - wr0), 32'd2);
    do_read(4'hC, 32'h400, 8'd1, 2'b01, 1'b0, nb, ok);
    check("mr_readback_done", 32'(ok), 32'd1);
    check("mr_readback0", rbuf[0], 32'h0000_0099);
    check("mr_readback1", rbuf[1], 32'h0000_0098);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, meaning the word-address width of the attached SRAM (2^MEM_AW 32-bit words).
REQ-002 SHALL have ports aclk in 1 (sole clock, rising edge) and areset in 1 (synchronous, active-high reset).
REQ-003 SHALL have AR ports: arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-004 SHALL have R ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-005 SHALL have AW ports: awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-006 SHALL have W ports: wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-007 SHALL have B ports: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have SRAM ports: ram_en out 1, ram_wen out 4, ram_addr out MEM_AW, ram_wdata out 32, ram_rdata in 32 (valid the cycle after ram_en with ram_wen=0).
REQ-009 SHALL leave arlock/arcache/arprot and awlock/awcache/awprot unconnected; they have no effect.

Function
REQ-010 SHALL be a single-outstanding AXI3 slave; FSM states IDLE, RD_ADDR, RD_DATA, WR_DATA, WR_RESP.
REQ-011 In IDLE, arready and awready SHALL be driven combinationally; all other states drive both 0.
REQ-012 If exactly one of arvalid/awvalid is high in IDLE, only that channel's ready SHALL be 1.
REQ-013 If both are high in IDLE, the channel not granted last SHALL win (1-bit toggle, reset value = write granted last, so read wins first).
REQ-014 On AR handshake SHALL latch arid, araddr[MEM_AW+1:2], arlen, arburst; clear beat counter; go to RD_ADDR.
REQ-015 RD_ADDR SHALL assert ram_en=1, ram_wen=0, ram_addr=current word address for one cycle, then go to RD_DATA.
REQ-016 On entry to RD_DATA SHALL capture ram_rdata into an rdata hold register; rvalid=1, rid=latched id, rresp=2'b00, rlast=(beat==arlen).
REQ-017 rdata/rid/rlast SHALL stay stable while rvalid=1 and rready=0.
REQ-018 On R handshake: if rlast, go to IDLE; else increment beat, advance address, go to RD_ADDR (minimum 2 cycles per beat).
REQ-019 Address advance: INCR (2'b01) adds 1 word modulo 2^MEM_AW; FIXED (2'b00) holds; WRAP (2'b10) treated as INCR.
REQ-020 arsize/awsize SHALL be ignored; every beat is a 32-bit word; write byte selection comes only from wstrb.
REQ-021 On AW handshake SHALL latch awid, awaddr, awlen, awburst; clear beat counter and error flag; go to WR_DATA.
REQ-022 WR_DATA SHALL assert wready=1; each W handshake SHALL drive ram_en=1, ram_wen=wstrb, ram_wdata=wdata, ram_addr=current word address in that same cycle.
REQ-023 Burst end SHALL be decided by the beat counter (beat==awlen), not by wlast; a wlast mismatch on any beat SHALL set the error flag.
REQ-024 After the final beat SHALL go to WR_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error flag set, else 2'b00; on B handshake go to IDLE.
REQ-025 wid SHALL be ignored.
REQ-026 ram_en SHALL be 0 in every cycle not covered by REQ-015/REQ-022.

Reset
REQ-027 While areset=1 at a rising edge: FSM->IDLE, arready=awready=rvalid=bvalid=wready=ram_en=0, ram_wen=0, rdata/rid/bid/bresp/rresp=0, grant toggle=write.
REQ-028 Reset mid-burst SHALL abandon the transaction without completing it or issuing further SRAM writes.
REQ-029 arready and awready SHALL be 0 during any cycle in which areset=1.

Configuration
REQ-030 With macro AXI_SRAM_SLAVE_DECERR_EN defined, a transaction whose start address has araddr/awaddr[31:MEM_AW+2] != 0 SHALL get DECERR (2'b11) on every R beat (rdata=0) or on B, with ram_en held 0 throughout.
REQ-031 Without AXI_SRAM_SLAVE_DECERR_EN, upper address bits SHALL be discarded and the access aliases into the SRAM.

Verification
REQ-032 Reset: areset=1 for 3 cycles with arvalid=awvalid=1 -> arready=awready=rvalid=bvalid=ram_en=0 throughout.
REQ-033 Single read: arid=4'h5, araddr=0x10, arlen=0, SRAM word 4 = 0xDEADBEEF -> ram_en 1 cycle after handshake, rvalid 2 cycles after handshake, rdata=0xDEADBEEF, rid=5, rlast=1, rresp=0.
REQ-034 INCR write burst: awaddr=0x20, awlen=3, wstrb=4'b0011 on beat 2 -> words 8..11 written, word 10 upper half unchanged; then bvalid with bresp=0, bid echoed.
REQ-035 Backpressure: 4-beat read with rready toggling 1/0 -> rdata stable during stalls, exactly 4 beats, rlast only on beat 4.
REQ-036 Contention: arvalid and awvalid held high together twice -> grant order read, write, read; wlast asserted early on a 2-beat write -> bresp=2'b10.
REQ-037 With AXI_SRAM_SLAVE_DECERR_EN and MEM_AW=16, araddr=0x0004_0000 -> rresp=2'b11, rdata=0, ram_en never asserted.
